// File: rtl/cmp_bist_pkg.sv
// Shared types and constants for the comparator BIST driver/checker.
// Imported by cmp_bist and lfsr16.
package cmp_bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD   = 3'd1;
    localparam state_t SETTLE = 3'd2;
    localparam state_t CHECK  = 3'd3;
    localparam state_t DONE   = 3'd4;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous reload.
// Reset and reload both return the register to seed.
module lfsr16
    import cmp_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/cmp_bist.sv
// BIST driver and checker for a magnitude comparator.
// Drives LFSR operands, checks eq/gt/lt flags against a golden compare.
module cmp_bist
    import cmp_bist_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          NUM_VECTORS = 10,
    parameter logic [15:0] SEED        = 16'hACE1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             eq_in,
    input  logic             gt_in,
    input  logic             lt_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [15:0]      vec_count
);

    state_t state;

    logic [15:0] lfsr;
    logic        lfsr_load;
    logic        lfsr_adv;

    logic [2:0]       gold;
    logic [2:0]       flags;
    logic             mis;
    logic [ERR_W-1:0] err_next;
    logic [15:0]      vec_next;
    logic             unused_lfsr;

    assign lfsr_load = (state == IDLE) && start;
    assign lfsr_adv  = (state == LOAD);

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (SEED),
        .advance (lfsr_adv),
        .q       (lfsr)
    );

    assign unused_lfsr = ^lfsr;

    // Any flag pattern other than the exact golden one is a single error.
    assign gold     = {a == b, a > b, a < b};
    assign flags    = {eq_in, gt_in, lt_in};
    assign mis      = (gold != flags);
    assign err_next = (mis && (err_count != ERR_MAX)) ? err_count + 8'd1
                                                      : err_count;
    assign vec_next = vec_count + 16'd1;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        err_count <= '0;
                        vec_count <= '0;
                        pass      <= 1'b0;
                    end
                end
                LOAD: begin
                    a <= lfsr[WIDTH-1:0];
                    // Every fourth vector is forced equal for EQ coverage.
                    if (vec_count[1:0] == 2'b11) begin
                        b <= lfsr[WIDTH-1:0];
                    end else begin
                        b <= lfsr[2*WIDTH-1:WIDTH];
                    end
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    err_count <= err_next;
                    vec_count <= vec_next;
                    if (vec_next == 16'(NUM_VECTORS)) begin
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_bist.sv
// Directed testbench for cmp_bist with behavioural comparator models.
// Vector table holds the hand-computed SEED=ACE1 operand sequence.
module tb_cmp_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [3:0]  a, b;
    logic        eq_in, gt_in, lt_in;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] vec_count;
    int          mode;

    logic        start2;
    logic [3:0]  a2, b2;
    logic        eq2, gt2, lt2;
    logic        busy2, done2, pass2;
    logic [7:0]  err2;
    logic [15:0] vec2;

    int checks = 0;
    int errors = 0;

    // mode 0: good, 1: gt stuck 0, 2: all flags stuck 1
    always_comb begin
        eq_in = (a == b);
        gt_in = (a > b);
        lt_in = (a < b);
        case (mode)
            1: gt_in = 1'b0;
            2: begin
                eq_in = 1'b1;
                gt_in = 1'b1;
                lt_in = 1'b1;
            end
            default: ;
        endcase
    end

    // Second comparator has its lt output inverted.
    always_comb begin
        eq2 = (a2 == b2);
        gt2 = (a2 > b2);
        lt2 = !(a2 < b2);
    end

    cmp_bist dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .eq_in     (eq_in),
        .gt_in     (gt_in),
        .lt_in     (lt_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count)
    );

    cmp_bist #(.NUM_VECTORS(300)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .a         (a2),
        .b         (b2),
        .eq_in     (eq2),
        .gt_in     (gt2),
        .lt_in     (lt2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err2),
        .vec_count (vec2)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
    } vec_t;

    typedef struct {
        int   mode;
        int   exp_err;
        logic exp_pass;
    } run_t;

    vec_t vt[10];
    run_t rt[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One start pulse, then watch 40 cycles counted from the start edge.
    task automatic run(input int m, input bit repulse, input bit chk_ab,
                       output int done_at, output int ndone);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_at = -1;
        ndone   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            if (repulse && n == 2) #1 start = 1'b1;
            if (repulse && n == 3) #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = n;
            end
            if (chk_ab && (n % 3 == 1) && n <= 28) begin
                chk($sformatf("a[%0d]", (n - 1) / 3), 32'(a), 32'(vt[(n-1)/3].a));
                chk($sformatf("b[%0d]", (n - 1) / 3), 32'(b), 32'(vt[(n-1)/3].b));
            end
        end
    endtask

    int da, nd;

    initial begin
        // LFSR states: ACE1 E270 7138 389C 1C4E 0E27 B313 ED89 C2C4 6162
        vt[0] = '{4'h1, 4'hE};
        vt[1] = '{4'h0, 4'h7};
        vt[2] = '{4'h8, 4'h3};
        vt[3] = '{4'hC, 4'hC};
        vt[4] = '{4'hE, 4'h4};
        vt[5] = '{4'h7, 4'h2};
        vt[6] = '{4'h3, 4'h1};
        vt[7] = '{4'h9, 4'h9};
        vt[8] = '{4'h4, 4'hC};
        vt[9] = '{4'h2, 4'h6};

        rt[0] = '{0, 0, 1'b1};
        rt[1] = '{1, 4, 1'b0};
        rt[2] = '{2, 10, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_vec", 32'(vec_count), 0);
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run(rt[i].mode, 1'b0, (i == 0), da, nd);
            chk($sformatf("done_at[%0d]", i), 32'(da), 30);
            chk($sformatf("ndone[%0d]", i), 32'(nd), 1);
            chk($sformatf("err[%0d]", i), 32'(err_count), 32'(rt[i].exp_err));
            chk($sformatf("vec[%0d]", i), 32'(vec_count), 10);
            chk($sformatf("pass[%0d]", i), 32'(pass), 32'(rt[i].exp_pass));
            chk($sformatf("idle[%0d]", i), 32'(busy), 0);
            if (i == 0) begin
                chk("hold_a", 32'(a), 32'(4'h2));
                chk("hold_b", 32'(b), 32'(4'h6));
            end
        end

        // start re-pulsed during CHECK; sequence must repeat from SEED
        run(0, 1'b1, 1'b1, da, nd);
        chk("repulse_done_at", 32'(da), 30);
        chk("repulse_ndone", 32'(nd), 1);
        chk("repulse_err", 32'(err_count), 0);
        chk("repulse_pass", 32'(pass), 1);

        // reset during SETTLE of vector 5
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_vec", 32'(vec_count), 5);
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pass", 32'(pass), 0);
        chk("abort_vec", 32'(vec_count), 0);
        chk("abort_a", 32'(a), 0);
        chk("abort_b", 32'(b), 0);
        @(negedge clk);
        chk("abort_done", 32'(done), 0);
        rst = 1'b0;
        nd = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 0);
        run(0, 1'b0, 1'b1, da, nd);
        chk("after_rst_done_at", 32'(da), 30);
        chk("after_rst_vec", 32'(vec_count), 10);
        chk("after_rst_pass", 32'(pass), 1);

        // 300 vectors, every one wrong: counter must saturate
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        da = -1;
        for (int n = 1; n <= 1000 && da < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done2) da = n;
        end
        chk("sat_done_at", 32'(da), 900);
        chk("sat_err", 32'(err2), 255);
        chk("sat_vec", 32'(vec2), 300);
        chk("sat_pass", 32'(pass2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
